// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants for the seven-segment scanner: hex-to-segment
//               table (active-low, bit 7 = dp) and the all-off patterns.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Entry n is the active-low pattern for hex digit n, dp bit left dark.
    localparam logic [15:0][7:0] c_HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_hex7seg.sv
`default_nettype none
// ============================================================================
// Module      : hex7seg
// Description : Combinational nibble to active-low 7-segment (g..a) decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module hex7seg
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    logic [7:0] w_pattern;

    assign w_pattern = c_HEX_SEG[i_nibble];
    assign o_seg     = w_pattern[6:0];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Eight-digit multiplexed 7-segment scanner with per-frame data
//               snapshot, leading-zero blanking and registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic        hold,
    input  logic        blank_lz,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  AN,
    output logic [7:0]  SEG,
    output logic        frame_done
);

    localparam int                 c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    logic [c_DIV_W-1:0] r_div;
    logic [2:0]         r_digit;
    logic [31:0]        r_shadow;

    logic               w_div_tc;
    logic               w_frame_start;
    logic [3:0]         w_nibble;
    logic [6:0]         w_seg7;
    logic [7:0]         w_zero_from;
    logic               w_blank;
    logic [7:0]         w_seg_next;

    assign w_div_tc      = (r_div == c_DIV_LAST);
    assign w_frame_start = w_div_tc && (r_digit == 3'd7);
    assign w_nibble      = r_shadow[{r_digit, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .i_nibble (w_nibble),
        .o_seg    (w_seg7)
    );

    // w_zero_from[i]: nibbles 7..i of the snapshot are all zero.
    for (genvar gi = 0; gi < 8; gi++) begin : g_lz
        assign w_zero_from[gi] = ~|r_shadow[31:4*gi];
    end

    assign w_blank    = blank_lz && (r_digit != 3'd0) && w_zero_from[r_digit];
    assign w_seg_next = w_blank ? SEG_BLANK : {~dp_mask[r_digit], w_seg7};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div      <= '0;
            r_digit    <= 3'd0;
            r_shadow   <= 32'd0;
            AN         <= AN_OFF;
            SEG        <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            r_div <= w_div_tc ? '0 : r_div + 1'b1;
            if (w_div_tc) begin
                r_digit <= r_digit + 3'd1;
            end
            // Snapshot lands together with digit 0, so a frame never tears.
            if (w_frame_start && !hold) begin
                r_shadow <= data;
            end
            frame_done <= w_frame_start;
            AN         <= ~(8'd1 << r_digit);
            SEG        <= w_seg_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Frame-by-frame vector bench for seg7_scan_driver (CLK_DIV=4),
//               with a CLK_DIV=1 instance checked for scan/frame cadence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic        hold;
    logic        blank_lz;
    logic [7:0]  dp_mask;
    logic [7:0]  AN, SEG, an1, seg1;
    logic        frame_done, fd1;

    always #5 clk = ~clk;

    seg7_scan_driver #(.CLK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .hold       (hold),
        .blank_lz   (blank_lz),
        .dp_mask    (dp_mask),
        .AN         (AN),
        .SEG        (SEG),
        .frame_done (frame_done)
    );

    seg7_scan_driver #(.CLK_DIV(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .hold       (hold),
        .blank_lz   (blank_lz),
        .dp_mask    (dp_mask),
        .AN         (an1),
        .SEG        (seg1),
        .frame_done (fd1)
    );

    typedef struct {
        logic [7:0] an;
        logic [7:0] seg;
        logic       fd;
        logic [7:0] an1;
        logic       fd1;
    } exp_t;

    // segs[d] is the expected SEG of digit d in the frame after data is captured.
    typedef struct {
        logic [31:0]     data;
        logic            hold;
        logic            blz;
        logic [7:0]      dp;
        logic [7:0][7:0] segs;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One window = one 32-cycle frame of the CLK_DIV=4 instance, aligned so
    // that cycle k shows digit (k-1)/4 and frame_done rises at k=32.
    task automatic run_window(input string tag, input logic [7:0][7:0] segs,
                              input int ncyc, input int chg_k, input logic [31:0] chg_data);
        exp_t e;
        int   d;
        for (int k = 1; k <= ncyc; k++) begin
            d = (k - 1) / 4;
            if (k == chg_k) data = chg_data;
            e.an  = ~(8'd1 << d);
            e.seg = segs[d];
            e.fd  = (k == 32);
            e.an1 = ~(8'd1 << ((k - 1) % 8));
            e.fd1 = ((k % 8) == 0);
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("%s k%0d AN", tag, k), AN, e.an);
            chk($sformatf("%s k%0d SEG", tag, k), SEG, e.seg);
            chk($sformatf("%s k%0d frame_done", tag, k), frame_done, e.fd);
            chk($sformatf("%s k%0d AN(div1)", tag, k), an1, e.an1);
            chk($sformatf("%s k%0d frame_done(div1)", tag, k), fd1, e.fd1);
        end
    endtask

    initial begin
        vecs[0] = '{32'h1234ABCD, 1'b0, 1'b0, 8'h00,
                    {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h88, 8'h83, 8'hC6, 8'hA1}};
        vecs[1] = '{32'h000000F0, 1'b0, 1'b1, 8'h00,
                    {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h8E, 8'hC0}};
        vecs[2] = '{32'hDEADBEEF, 1'b1, 1'b1, 8'h83,
                    {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0E, 8'h40}};
        vecs[3] = '{32'h00000000, 1'b0, 1'b1, 8'h01,
                    {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h40}};
        vecs[4] = '{32'h56789EF0, 1'b0, 1'b1, 8'h10,
                    {8'h92, 8'h82, 8'hF8, 8'h00, 8'h90, 8'h86, 8'h8E, 8'hC0}};
        vecs[5] = '{32'h01000000, 1'b0, 1'b1, 8'h00,
                    {8'hFF, 8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}};
        vecs[6] = '{32'h00000000, 1'b0, 1'b0, 8'hFF, {8{8'h40}}};
        vecs[7] = '{32'h00000007, 1'b0, 1'b1, 8'h00,
                    {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8}};

        rst = 1'b1; data = 32'd0; hold = 1'b0; blank_lz = 1'b0; dp_mask = 8'h00;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("reset AN", AN, 8'hFF);
            chk("reset SEG", SEG, 8'hFF);
            chk("reset frame_done", frame_done, 1'b0);
            chk("reset AN(div1)", an1, 8'hFF);
            chk("reset SEG(div1)", seg1, 8'hFF);
        end

        // Window 0 shows the cleared snapshot; data for vector 0 is captured at its end.
        data = vecs[0].data;
        hold = vecs[0].hold;
        rst  = 1'b0;
        run_window("w0", {8{8'hC0}}, 32, 0, 32'd0);

        for (int i = 0; i < 8; i++) begin
            blank_lz = vecs[i].blz;
            dp_mask  = vecs[i].dp;
            if (i < 7) begin
                data = vecs[i + 1].data;
                hold = vecs[i + 1].hold;
            end else begin
                data = 32'h11111111;
                hold = 1'b0;
            end
            run_window($sformatf("v%0d", i), vecs[i].segs, 32, 0, 32'd0);
        end

        // Mid-frame data change is invisible until the next frame start.
        blank_lz = 1'b0;
        dp_mask  = 8'h00;
        run_window("midchg", {8{8'hF9}}, 32, 13, 32'h22222222);
        run_window("newframe", {8{8'hA4}}, 10, 0, 32'd0);

        // Mid-frame reset clears the snapshot rather than reloading it.
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst AN", AN, 8'hFF);
        chk("midrst SEG", SEG, 8'hFF);
        chk("midrst frame_done", frame_done, 1'b0);
        chk("midrst AN(div1)", an1, 8'hFF);
        rst = 1'b0;
        run_window("postrst", {8{8'hC0}}, 32, 0, 32'd0);
        run_window("recapture", {8{8'hA4}}, 32, 0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
